// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and one-hot helper for the stream demultiplexer
package stream_demux_pkg;
  localparam int DROP_CNT_W = 8;
  localparam int SEL_MAX_W  = 32;

  // Callers zero-extend narrower selectors; padding zeros do not change one-hotness.
  function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/stream_demultiplexer_if.sv
// rtl/stream_demultiplexer_if.sv - input stream and per-channel output handshake bundle
interface stream_demultiplexer_if #(
  parameter int WIDTH   = 4,
  parameter int OUTPUTS = 4
);
  logic [WIDTH-1:0]         in_data;
  logic [OUTPUTS-1:0]       in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*OUTPUTS-1:0] out_data;
  logic [OUTPUTS-1:0]       out_valid;
  logic [OUTPUTS-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register for a single demultiplexer channel
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Data is only replaced on load, so the last word remains visible after draining.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/stream_demultiplexer.sv
// rtl/stream_demultiplexer.sv - registered 1-to-N stream demux steered by one-hot in_sel
// Define STREAM_DEMUX_ROUND_ROBIN_EN to ignore in_sel and rotate destinations internally.
module stream_demultiplexer
  import stream_demux_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int OUTPUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_demultiplexer_if.slave bus,
  output logic                  sel_err,
  output logic [DROP_CNT_W-1:0] drop_count
);
  logic [OUTPUTS-1:0]       free_slots, dest, load;
  logic [OUTPUTS-1:0]       slot_valid;
  logic [WIDTH*OUTPUTS-1:0] slot_data;
  logic                     sel_ok, in_ready, accept, drop;
  logic                     sel_err_d, sel_err_q;
  logic [DROP_CNT_W-1:0]    drop_count_d, drop_count_q;

  assign free_slots = ~slot_valid | bus.out_ready;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
  logic [OUTPUTS-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = {ptr_q[OUTPUTS-2:0], ptr_q[OUTPUTS-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= OUTPUTS'(1);
    else     ptr_q <= ptr_d;
  end

  assign dest   = ptr_q;
  assign sel_ok = 1'b1;
`else
  assign dest   = bus.in_sel;
  assign sel_ok = is_onehot(SEL_MAX_W'(bus.in_sel));
`endif

  // Bad selectors are always accepted so a malformed word can never stall the producer.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) in_ready = sel_ok ? |(free_slots & dest) : 1'b1;
  end

  assign accept = bus.in_valid & in_ready;
  assign load   = (accept && sel_ok) ? dest : '0;
  assign drop   = accept & ~sel_ok;

  always_comb begin
    sel_err_d    = drop;
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != {DROP_CNT_W{1'b1}}) drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      sel_err_q    <= sel_err_d;
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar j = 0; j < OUTPUTS; j++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[j]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[j]),
      .out_data  (slot_data[j*WIDTH +: WIDTH]),
      .out_valid (slot_valid[j])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = slot_data;
  assign bus.out_valid = slot_valid;
  assign sel_err       = sel_err_q;
  assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb/tb_stream_demultiplexer.sv - directed self-checking bench for stream_demultiplexer
module tb_stream_demultiplexer;
  logic       clk = 1'b0;
  logic       rst;
  logic       sel_err;
  logic [7:0] drop_count;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  stream_demultiplexer_if #(.WIDTH(4), .OUTPUTS(4)) bus ();

  stream_demultiplexer #(.WIDTH(4), .OUTPUTS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sel_err    (sel_err),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] sel, input logic [3:0] d);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 4'b0000;
    drive(1'b1, 4'b0001, 4'h5);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    bus.out_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_v;
      logic [3:0] lane;
      drive(1'b1, 4'b0000, 4'(i + 1));
      #1 chk("rr_in_ready", bus.in_ready, 1);
      step();
      exp_v = 4'(1 << (i % 4)) | ((i >= 1) ? 4'b0010 : 4'b0000);
      lane  = bus.out_data[(i % 4)*4 +: 4];
      chk("rr_out_valid", bus.out_valid, exp_v);
      chk("rr_lane_data", lane, 4'(i + 1));
    end
    drive(1'b1, 4'b0000, 4'h8);
    #1 chk("rr_stall_in_ready", bus.in_ready, 0);
    step();
    chk("rr_stall_out_valid", bus.out_valid, 4'b0010);
    #1 chk("rr_stall_hold", bus.in_ready, 0);
    bus.out_ready = 4'b1111;
    #1 chk("rr_unstall_in_ready", bus.in_ready, 1);
    step();
    chk("rr_ch1_valid", bus.out_valid, 4'b0010);
    chk("rr_ch1_data", bus.out_data[7:4], 4'h8);
    chk("rr_sel_err", sel_err, 0);
    chk("rr_drop_count", drop_count, 0);
    drive(1'b0, 4'b0000, 4'h0);
`else
    drive(1'b1, 4'b0100, 4'hA);
    #1 chk("ch2_empty_ready", bus.in_ready, 1);
    step();
    chk("ch2_out_valid", bus.out_valid, 4'b0100);
    chk("ch2_out_data", bus.out_data[11:8], 4'hA);
    drive(1'b1, 4'b0100, 4'h5);
    #1 chk("ch2_full_ready", bus.in_ready, 0);

    drive(1'b1, 4'b0010, 4'h3);
    #1 chk("ch1_bypass_ready", bus.in_ready, 1);
    step();
    chk("ch1_out_valid", bus.out_valid, 4'b0110);
    chk("ch1_out_data", bus.out_data[7:4], 4'h3);
    chk("ch2_held_data", bus.out_data[11:8], 4'hA);

    bus.out_ready = 4'b0001;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 4'b0001, 4'(i));
      #1 chk("ch0_stream_ready", bus.in_ready, 1);
      step();
      chk("ch0_stream_data", bus.out_data[3:0], 4'(i));
    end
    chk("ch0_stream_valid", bus.out_valid, 4'b0111);
    drive(1'b0, 4'b0000, 4'h0);
    step();
    chk("ch0_drained_valid", bus.out_valid, 4'b0110);
    chk("ch0_drained_data", bus.out_data[3:0], 4'h3);

    bus.out_ready = 4'b0000;
    drive(1'b1, 4'b0110, 4'hF);
    #1 chk("bad_sel_ready", bus.in_ready, 1);
    step();
    chk("bad1_sel_err", sel_err, 1);
    chk("bad1_drop_count", drop_count, 1);
    chk("bad1_out_valid", bus.out_valid, 4'b0110);
    drive(1'b1, 4'b0000, 4'hE);
    step();
    chk("bad2_sel_err", sel_err, 1);
    chk("bad2_drop_count", drop_count, 2);
    drive(1'b0, 4'b0000, 4'h0);
    step();
    chk("sel_err_clear", sel_err, 0);
    chk("drop_count_hold", drop_count, 2);
    chk("bad_out_valid", bus.out_valid, 4'b0110);
    chk("bad_out_data", bus.out_data, 16'h0A33);

    drive(1'b1, 4'b1111, 4'h0);
    repeat (300) step();
    drive(1'b0, 4'b0000, 4'h0);
    step();
    chk("drop_count_sat", drop_count, 255);

    drive(1'b1, 4'b0001, 4'h7);
    step();
    drive(1'b1, 4'b1000, 4'h9);
    step();
    drive(1'b1, 4'b0001, 4'h4);
    chk("full_out_valid", bus.out_valid, 4'b1111);
    chk("full_out_data", bus.out_data, 16'h9A37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_data", bus.out_data, 0);
    chk("async_rst_drop", drop_count, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    drive(1'b1, 4'b1000, 4'h6);
    step();
    drive(1'b0, 4'b0000, 4'h0);
    chk("post_rst_valid", bus.out_valid, 4'b1000);
    chk("post_rst_data", bus.out_data, 16'h6000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
